// File: rtl/apb_mst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mst_pkg
//  Description : State encoding, register struct and reset constant for apb_mst
//  Revision    : 1.0  initial release
// ============================================================================
package apb_mst_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

    typedef struct packed {
        apb_mst_state_t state;
        logic [31:0]    paddr;
        logic           pwrite;
        logic [31:0]    pwdata;
        logic [3:0]     pstrb;
        logic           pselx;
        logic           penable;
        logic [31:0]    rdata;
        logic           err;
        logic [15:0]    tmo_cnt;
    } apb_mst_registers;

    localparam apb_mst_registers apb_mst_r_reset = '{
        state   : IDLE,
        paddr   : 32'h0,
        pwrite  : 1'b0,
        pwdata  : 32'h0,
        pstrb   : 4'h0,
        pselx   : 1'b0,
        penable : 1'b0,
        rdata   : 32'h0,
        err     : 1'b0,
        tmo_cnt : 16'h0
    };

endpackage
`default_nettype wire

// File: rtl/types_amba_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : types_amba_pkg
//  Description : AMBA APB bus signal bundles (master-to-slave, slave-to-master)
//  Revision    : 1.0  initial release
// ============================================================================
package types_amba_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        pselx;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_in_type;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
    } apb_out_type;

endpackage
`default_nettype wire

// File: rtl/apb_mst.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mst
//  Description : Single-outstanding APB initiator with valid/ready request and
//                response channels. Define APB_MST_TIMEOUT_EN to abort ACCESS
//                phases that wait TIMEOUT_CYCLES cycles without pready.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_mst #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_sys_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [31:0]               i_req_addr,
    input  logic                      i_req_write,
    input  logic [31:0]               i_req_wdata,
    input  logic [3:0]                i_req_wstrb,
    output logic                      o_resp_valid,
    input  logic                      i_resp_ready,
    output logic [31:0]               o_resp_rdata,
    output logic                      o_resp_err,
    output types_amba_pkg::apb_in_type  o_apbi,
    input  types_amba_pkg::apb_out_type i_apbo
);
    import apb_mst_pkg::*;

    localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    apb_mst_registers r_regs;
    apb_mst_registers w_next;

    always_comb begin
        w_next = r_regs;
        case (r_regs.state)
            IDLE: begin
                if (i_req_valid) begin
                    w_next.paddr   = i_req_addr;
                    w_next.pwrite  = i_req_write;
                    w_next.pwdata  = i_req_wdata;
                    w_next.pstrb   = i_req_write ? i_req_wstrb : 4'h0;
                    w_next.pselx   = 1'b1;
                    w_next.penable = 1'b0;
                    w_next.state   = SETUP;
                end
            end
            SETUP: begin
                w_next.penable = 1'b1;
                w_next.tmo_cnt = 16'h0;
                w_next.state   = ACCESS;
            end
            ACCESS: begin
                if (i_apbo.pready) begin
                    w_next.rdata   = r_regs.pwrite ? 32'h0 : i_apbo.prdata;
                    w_next.err     = i_apbo.pslverr;
                    w_next.pselx   = 1'b0;
                    w_next.penable = 1'b0;
                    w_next.state   = RESP;
                end else if (r_regs.tmo_cnt != C_TMO_LAST) begin
                    w_next.tmo_cnt = r_regs.tmo_cnt + 16'h1;
                end
`ifdef APB_MST_TIMEOUT_EN
                else begin
                    w_next.rdata   = 32'h0;
                    w_next.err     = 1'b1;
                    w_next.pselx   = 1'b0;
                    w_next.penable = 1'b0;
                    w_next.state   = RESP;
                end
`endif
            end
            RESP: begin
                // Bus is already idle here; only the response handshake matters.
                if (i_resp_ready) begin
                    w_next.state = IDLE;
                end
            end
            default: begin
                w_next = apb_mst_r_reset;
            end
        endcase
        if (i_sys_rst) begin
            w_next = apb_mst_r_reset;
        end
    end

    always_ff @(posedge i_clk) begin
        r_regs <= w_next;
    end

    assign o_req_ready    = (r_regs.state == IDLE);
    assign o_resp_valid   = (r_regs.state == RESP);
    assign o_resp_rdata   = r_regs.rdata;
    assign o_resp_err     = r_regs.err;

    assign o_apbi.paddr   = r_regs.paddr;
    assign o_apbi.pprot   = 3'b000;
    assign o_apbi.pselx   = r_regs.pselx;
    assign o_apbi.penable = r_regs.penable;
    assign o_apbi.pwrite  = r_regs.pwrite;
    assign o_apbi.pwdata  = r_regs.pwdata;
    assign o_apbi.pstrb   = r_regs.pstrb;

endmodule
`default_nettype wire

// File: tb/tb_apb_mst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_mst
//  Description : Self-checking bench for apb_mst with a transaction-level model
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_mst;
    import types_amba_pkg::*;

`ifdef APB_MST_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    apb_in_type  apbi;
    apb_out_type apbo = '0;

    int total = 0;
    int bad   = 0;

    logic [31:0] nxt_addr, nxt_wdata;
    logic        nxt_write;
    logic [3:0]  nxt_wstrb;

    apb_mst #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk        (clk),
        .i_sys_rst    (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .i_req_write  (req_write),
        .i_req_wdata  (req_wdata),
        .i_req_wstrb  (req_wstrb),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .o_apbi       (apbi),
        .i_apbo       (apbo)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input logic [3:0] st);
        chk($sformatf("%s_paddr", tag),  apbi.paddr, a);
        chk($sformatf("%s_pwrite", tag), 32'(apbi.pwrite), 32'(w));
        chk($sformatf("%s_pwdata", tag), apbi.pwdata, wd);
        chk($sformatf("%s_pstrb", tag),  32'(apbi.pstrb), 32'(st));
        chk($sformatf("%s_pprot", tag),  32'(apbi.pprot), 32'h0);
    endtask

    // One complete transfer; expected values follow from the request and slave reply.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] ws, input int waits, input logic [31:0] rd,
                          input logic se, input int rdly, input bit queue_next);
        logic [31:0] exp_rd;
        logic [3:0]  exp_strb;
        exp_strb = w ? ws : 4'h0;
        exp_rd   = w ? 32'h0 : rd;
        chk("req_ready_idle", 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd; req_wstrb = ws;
        @(negedge clk);
        req_valid = 1'b0;
        chk("setup_psel", 32'(apbi.pselx), 32'h1);
        chk("setup_pen", 32'(apbi.penable), 32'h0);
        chk("setup_req_ready", 32'(req_ready), 32'h0);
        chk_bus("setup", a, w, wd, exp_strb);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            chk("access_psel", 32'(apbi.pselx), 32'h1);
            chk("access_pen", 32'(apbi.penable), 32'h1);
            chk("access_resp_valid", 32'(resp_valid), 32'h0);
            chk_bus("access", a, w, wd, exp_strb);
            apbo.pready  = (i == waits);
            apbo.prdata  = (i == waits) ? rd : $urandom;
            apbo.pslverr = (i == waits) ? se : 1'($urandom);
        end
        @(negedge clk);
        apbo = '0;
        chk("resp_psel", 32'(apbi.pselx), 32'h0);
        chk("resp_pen", 32'(apbi.penable), 32'h0);
        chk("resp_valid", 32'(resp_valid), 32'h1);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", 32'(resp_err), 32'(se));
        for (int i = 0; i < rdly; i++) begin
            if (queue_next) begin
                req_valid = 1'b1; req_addr = nxt_addr; req_write = nxt_write;
                req_wdata = nxt_wdata; req_wstrb = nxt_wstrb;
            end
            @(negedge clk);
            chk("bp_resp_valid", 32'(resp_valid), 32'h1);
            chk("bp_rdata", resp_rdata, exp_rd);
            chk("bp_err", 32'(resp_err), 32'(se));
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_psel", 32'(apbi.pselx), 32'h0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_resp_valid", 32'(resp_valid), 32'h0);
        chk("post_psel", 32'(apbi.pselx), 32'h0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Reset state; a stray pready while idle must have no effect.
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'h0);
        chk("rst_psel", 32'(apbi.pselx), 32'h0);
        chk("rst_pen", 32'(apbi.penable), 32'h0);
        chk_bus("rst", 32'h0, 1'b0, 32'h0, 4'h0);
        apbo.pready = 1'b1; apbo.pslverr = 1'b1;
        @(negedge clk);
        apbo = '0;
        chk("stray_pready_resp", 32'(resp_valid), 32'h0);
        chk("stray_pready_psel", 32'(apbi.pselx), 32'h0);

        do_txn(32'h0000_0004, 1'b0, 32'h0, 4'hF, 0, 32'h0000_0003, 1'b0, 0, 1'b0);
        do_txn(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'h5, 3, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        do_txn(32'h0000_0020, 1'b0, 32'h0, 4'h0, 1, 32'h0000_1234, 1'b1, 0, 1'b0);

        nxt_addr = 32'h0000_0044; nxt_write = 1'b1; nxt_wdata = 32'hCAFE_F00D; nxt_wstrb = 4'hC;
        do_txn(32'h0000_0040, 1'b0, 32'h0, 4'h0, 0, 32'h5555_AAAA, 1'b0, 5, 1'b1);
        do_txn(nxt_addr, nxt_write, nxt_wdata, nxt_wstrb, 0, 32'h0, 1'b0, 0, 1'b0);

        // Reset while in ACCESS discards the transfer.
        req_valid = 1'b1; req_addr = 32'h80; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_access_pen", 32'(apbi.penable), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_psel", 32'(apbi.pselx), 32'h0);
        chk("mid_rst_pen", 32'(apbi.penable), 32'h0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
        @(negedge clk);
        chk("mid_rst_req_ready", 32'(req_ready), 32'h1);
        chk("mid_rst_resp_valid2", 32'(resp_valid), 32'h0);

        for (int k = 0; k < 16; k++) begin
            do_txn($urandom, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 4),
                   $urandom, 1'($urandom), $urandom_range(0, 3), 1'b0);
        end

        req_valid = 1'b1; req_addr = 32'h100; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        apbo.prdata = 32'hBAD0_BAD0;
`ifdef APB_MST_TIMEOUT_EN
        n = 0;
        while (apbi.penable === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_access_cycles", 32'(n), 32'd8);
        chk("tmo_resp_valid", 32'(resp_valid), 32'h1);
        chk("tmo_err", 32'(resp_err), 32'h1);
        chk("tmo_rdata", resp_rdata, 32'h0);
        chk("tmo_psel", 32'(apbi.pselx), 32'h0);
`else
        n = 0;
        while (apbi.penable === 1'b1 && resp_valid === 1'b0 && n < 1100) begin
            n++;
            @(negedge clk);
        end
        chk("stall_access_cycles", 32'(n), 32'd1100);
        chk("stall_psel", 32'(apbi.pselx), 32'h1);
        chk("stall_resp_valid", 32'(resp_valid), 32'h0);
        apbo.pready = 1'b1; apbo.prdata = 32'h0000_0077;
        @(negedge clk);
        apbo = '0;
        chk("stall_done_valid", 32'(resp_valid), 32'h1);
        chk("stall_done_rdata", resp_rdata, 32'h0000_0077);
        chk("stall_done_err", 32'(resp_err), 32'h0);
`endif
        apbo = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("final_req_ready", 32'(req_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
